dual_slope_sequencer: RTL and testbench

- Digital conversion controller for the MC14433-style 3½-digit dual-slope ADC.
- Sequences the analog switch phases: auto-zero, signal integrate, reference de-integrate.
- Counts de-integration time in BCD, latches the result, and drives the multiplexed digit-strobe/BCD output.
- Sits between the clock generator and the analog front end / display latch. It is the block that drives the existing counter and shift chain.

---
 rtl/mc14433_defs.sv | 14 +
 rtl/bcd_counter_3p5.sv | 48 ++++
 rtl/dual_slope_sequencer.sv | 163 ++++++++++++++++
 tb/tb_dual_slope_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mc14433_defs.sv
// Shared definitions for the MC14433-style dual-slope conversion sequencer:
// FSM state encodings, the 3½-digit BCD full-scale value and the blank digit code.
package mc14433_defs;

    localparam logic [1:0] ST_AZ    = 2'd0;
    localparam logic [1:0] ST_INT   = 2'd1;
    localparam logic [1:0] ST_DEINT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [12:0] MAX_BCD = 13'h1999;
    localparam logic [3:0]  BLANK   = 4'hF;
    localparam logic [3:0]  BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_counter_3p5.sv
// 3½-digit BCD up-counter (1+4+4+4 bits) with synchronous clear and enable.
// It saturates at 1999 and flags that value on at_max_o.
module bcd_counter_3p5
    import mc14433_defs::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [12:0] value_o,
    output logic        at_max_o
);

    logic [12:0] cnt_q;
    logic [12:0] cnt_d;
    logic        carry;

    assign value_o  = cnt_q;
    assign at_max_o = (cnt_q == MAX_BCD);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b1;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_max_o) begin
            for (int i = 0; i < 3; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == BCD_NINE) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            if (carry) begin
                cnt_d[12] = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dual_slope_sequencer.sv
// Dual-slope ADC conversion controller (AZ -> INT -> DEINT -> LATCH) with BCD result
// latch and multiplexed digit scan. Define OVERRANGE_BLANK_EN to blank digits on overrange.
module dual_slope_sequencer
    import mc14433_defs::*;
#(
    parameter int AZ_CNT   = 1000,
    parameter int INT_CNT  = 2000,
    parameter int SCAN_DIV = 16
) (
    input  logic       CP,
    input  logic       R,
    input  logic       CMP,
    input  logic       POL,
    input  logic       DU,
    output logic       AZ_EN,
    output logic       INT_EN,
    output logic       DEINT_EN,
    output logic       EOC,
    output logic       SIGN,
    output logic       OR_N,
    output logic [3:0] DS,
    output logic [3:0] Q
);

    localparam logic [11:0] AZ_LAST   = 12'(AZ_CNT - 1);
    localparam logic [11:0] INT_LAST  = 12'(INT_CNT - 1);
    localparam logic [7:0]  SCAN_LAST = 8'(SCAN_DIV - 1);

    logic [1:0]  state_q, state_d, state_nx;
    logic [11:0] phase_q, phase_d;
    logic        run_q;
    logic        sign_r_q, sign_r_d;
    logic        ovr_q, ovr_d;
    logic [12:0] result_q;
    logic        sign_q, or_n_q;
    logic        az_en_q, int_en_q, deint_en_q, eoc_q;
    logic [7:0]  scan_q;
    logic [3:0]  ds_q;
    logic [3:0]  q_dig;

    logic [12:0] bcd_val;
    logic        bcd_max;
    logic        bcd_en;
    logic        bcd_clr;

    assign bcd_en  = run_q && (state_q == ST_DEINT) && !CMP && !bcd_max;
    assign bcd_clr = R || (run_q && (state_q == ST_LATCH));

    bcd_counter_3p5 u_bcd (
        .clk_i    (CP),
        .clr_i    (bcd_clr),
        .en_i     (bcd_en),
        .value_o  (bcd_val),
        .at_max_o (bcd_max)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 12'd1;
        sign_r_d = sign_r_q;
        ovr_d    = ovr_q;
        case (state_q)
            ST_AZ: begin
                if (phase_q == AZ_LAST) begin
                    state_d = ST_INT;
                    phase_d = '0;
                end
            end
            ST_INT: begin
                if (phase_q == INT_LAST) begin
                    state_d  = ST_DEINT;
                    phase_d  = '0;
                    sign_r_d = POL;
                end
            end
            ST_DEINT: begin
                // A comparator crossing on the 1999 count still counts as a valid reading.
                if (CMP || bcd_max) begin
                    state_d = ST_LATCH;
                    phase_d = '0;
                    ovr_d   = bcd_max && !CMP;
                end
            end
            default: begin
                state_d = ST_AZ;
                phase_d = '0;
            end
        endcase
    end

    // The first cycle out of reset shows AZ cycle 1 without advancing the phase count.
    assign state_nx = run_q ? state_d : state_q;

    always_ff @(posedge CP) begin
        if (R) begin
            state_q    <= ST_AZ;
            phase_q    <= '0;
            run_q      <= 1'b0;
            sign_r_q   <= 1'b0;
            ovr_q      <= 1'b0;
            result_q   <= '0;
            sign_q     <= 1'b0;
            or_n_q     <= 1'b1;
            az_en_q    <= 1'b0;
            int_en_q   <= 1'b0;
            deint_en_q <= 1'b0;
            eoc_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q  <= state_d;
                phase_q  <= phase_d;
                sign_r_q <= sign_r_d;
                ovr_q    <= ovr_d;
                if (state_q == ST_LATCH && DU) begin
                    result_q <= bcd_val;
                    sign_q   <= sign_r_q;
                    or_n_q   <= ~ovr_q;
                end
            end
            az_en_q    <= (state_nx == ST_AZ);
            int_en_q   <= (state_nx == ST_INT);
            deint_en_q <= (state_nx == ST_DEINT);
            eoc_q      <= (state_nx == ST_LATCH);
        end
    end

    always_ff @(posedge CP) begin
        if (R) begin
            scan_q <= '0;
            ds_q   <= 4'b1000;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            ds_q   <= {ds_q[0], ds_q[3:1]};
        end else begin
            scan_q <= scan_q + 8'd1;
        end
    end

    always_comb begin
        case (ds_q)
            4'b0100: q_dig = result_q[11:8];
            4'b0010: q_dig = result_q[7:4];
            4'b0001: q_dig = result_q[3:0];
            default: q_dig = {1'b0, sign_q, ~or_n_q, result_q[12]};
        endcase
`ifdef OVERRANGE_BLANK_EN
        if (!or_n_q && !ds_q[3]) begin
            q_dig = BLANK;
        end
`endif
    end

    assign AZ_EN    = az_en_q;
    assign INT_EN   = int_en_q;
    assign DEINT_EN = deint_en_q;
    assign EOC      = eoc_q;
    assign SIGN     = sign_q;
    assign OR_N     = or_n_q;
    assign DS       = ds_q;
    assign Q        = q_dig;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Directed bench for dual_slope_sequencer (AZ_CNT=8, INT_CNT=20, SCAN_DIV=2) with a
// result scoreboard; honours OVERRANGE_BLANK_EN when compiled with it.
module tb_dual_slope_sequencer;

    localparam int AZ_CNT   = 8;
    localparam int INT_CNT  = 20;
    localparam int SCAN_DIV = 2;

    typedef struct packed {
        logic [12:0] res;
        logic        sign;
        logic        or_n;
    } exp_t;

    logic       CP = 1'b0;
    logic       R, CMP, POL, DU;
    logic       AZ_EN, INT_EN, DEINT_EN, EOC, SIGN, OR_N;
    logic [3:0] DS, Q;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t shown;

    dual_slope_sequencer #(
        .AZ_CNT   (AZ_CNT),
        .INT_CNT  (INT_CNT),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CP       (CP),
        .R        (R),
        .CMP      (CMP),
        .POL      (POL),
        .DU       (DU),
        .AZ_EN    (AZ_EN),
        .INT_EN   (INT_EN),
        .DEINT_EN (DEINT_EN),
        .EOC      (EOC),
        .SIGN     (SIGN),
        .OR_N     (OR_N),
        .DS       (DS),
        .Q        (Q)
    );

    always #5 CP = ~CP;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge CP);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] to_bcd(input int v);
        logic [12:0] r;
        r[12]   = (v >= 1000);
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3:0] exp_q(input logic [3:0] ds, input exp_t e);
        logic [3:0] d;
        case (ds)
            4'b0100: d = e.res[11:8];
            4'b0010: d = e.res[7:4];
            4'b0001: d = e.res[3:0];
            default: return {1'b0, e.sign, ~e.or_n, e.res[12]};
        endcase
`ifdef OVERRANGE_BLANK_EN
        if (!e.or_n) d = 4'hF;
`endif
        return d;
    endfunction

    task automatic check_cycle(input string tag);
        check({tag, "_excl"}, 32'($countones({AZ_EN, INT_EN, DEINT_EN}) <= 1), 32'd1);
        check({tag, "_ds1hot"}, 32'($onehot(DS)), 32'd1);
        check({tag, "_q"}, 32'(Q), 32'(exp_q(DS, shown)));
    endtask

    // Entered in AZ cycle 1; returns in the AZ cycle 1 of the next conversion.
    task automatic conversion(input int cmp_cycle, input logic pol, input logic du,
                              input bit chk_ds);
        int   n;
        exp_t e;
        n = 0;
        while (AZ_EN === 1'b1 && n < 100) begin
            if (chk_ds) check("ds_rot", 32'(DS), 32'(4'b1000 >> (((n + 1) / 2) % 4)));
            check_cycle("az");
            n++;
            cyc();
        end
        check("az_len", 32'(n), 32'(AZ_CNT));
        n = 0;
        while (INT_EN === 1'b1 && n < 100) begin
            POL = (n == INT_CNT - 1) ? pol : ~pol;
            check_cycle("int");
            n++;
            cyc();
        end
        check("int_len", 32'(n), 32'(INT_CNT));
        POL = ~pol;
        DU  = du;
        n   = 0;
        while (DEINT_EN === 1'b1 && n < 2100) begin
            n++;
            CMP = (n == cmp_cycle);
            check_cycle("deint");
            cyc();
        end
        CMP = 1'b0;
        check("deint_len", 32'(n), 32'((cmp_cycle > 0) ? cmp_cycle : 2000));
        check("latch_eoc", 32'(EOC), 32'd1);
        check("latch_en", 32'({AZ_EN, INT_EN, DEINT_EN}), 32'd0);
        if (du) begin
            e.res  = (cmp_cycle > 0) ? to_bcd(cmp_cycle - 1) : 13'h1999;
            e.sign = pol;
            e.or_n = (cmp_cycle != 0);
        end else begin
            e = shown;
        end
        sb.push_back(e);
        cyc();
        DU = 1'b1;
        check("eoc_pulse", 32'(EOC), 32'd0);
        check("az_restart", 32'(AZ_EN), 32'd1);
        e = sb.pop_front();
        check("sign", 32'(SIGN), 32'(e.sign));
        check("or_n", 32'(OR_N), 32'(e.or_n));
        shown = e;
    endtask

    initial begin
        int n;
        R     = 1'b1;
        CMP   = 1'b0;
        POL   = 1'b0;
        DU    = 1'b1;
        shown = '{res: 13'h0, sign: 1'b0, or_n: 1'b1};
        repeat (3) cyc();
        check("rst_en", 32'({AZ_EN, INT_EN, DEINT_EN, EOC}), 32'd0);
        check("rst_sign", 32'(SIGN), 32'd0);
        check("rst_or_n", 32'(OR_N), 32'd1);
        check("rst_ds", 32'(DS), 32'(4'b1000));
        check("rst_q", 32'(Q), 32'd0);
        R = 1'b0;
        cyc();

        conversion(1235, 1'b1, 1'b1, 1'b1);   // 1234, positive
        conversion(501,  1'b0, 1'b0, 1'b0);   // 0500 with DU=0: display keeps 1234
        conversion(0,    1'b0, 1'b1, 1'b0);   // overrange 1999
        conversion(1,    1'b1, 1'b1, 1'b0);   // immediate crossing: 0000
        conversion(2000, 1'b0, 1'b1, 1'b0);   // crossing on 1999: valid, not overrange

        n = 0;
        while (AZ_EN === 1'b1 && n < 100) begin
            check_cycle("pre_rst_az");
            n++;
            cyc();
        end
        check("pre_rst_az_len", 32'(n), 32'(AZ_CNT));
        repeat (5) begin
            check("pre_rst_int", 32'(INT_EN), 32'd1);
            check_cycle("pre_rst");
            cyc();
        end
        R = 1'b1;
        cyc();
        check("midrst_en", 32'({AZ_EN, INT_EN, DEINT_EN, EOC}), 32'd0);
        check("midrst_ds", 32'(DS), 32'(4'b1000));
        check("midrst_q", 32'(Q), 32'd0);
        check("midrst_or_n", 32'(OR_N), 32'd1);
        check("midrst_sign", 32'(SIGN), 32'd0);
        R     = 1'b0;
        shown = '{res: 13'h0, sign: 1'b0, or_n: 1'b1};
        cyc();
        conversion(3, 1'b1, 1'b1, 1'b1);      // full AZ after abort, then 0002
        repeat (8) begin
            check_cycle("final");
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
